// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states
//   GRANT_W     : width of requester indices (grant_id, rr pointer)
//   MAX_NUM_REQ : largest supported number of requesters
package uart_arb_pkg;

  localparam int unsigned GRANT_W     = 3;
  localparam int unsigned MAX_NUM_REQ = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req  : request vector
//   i_ptr  : highest-priority index (must be < NUM_REQ)
//   o_gnt  : one-hot grant, zero when nothing is requested
//   o_idx  : index of the granted requester
//   o_any  : at least one request is present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GRANT_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_any
);

  int unsigned w_dist;
  int unsigned w_best_dist;
  int unsigned w_best;

  // Winner is the valid requester with the smallest forward distance from the pointer.
  always_comb begin
    o_any       = 1'b0;
    w_dist      = 0;
    w_best      = 0;
    w_best_dist = NUM_REQ;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 32'(i_ptr)) % NUM_REQ;
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = i;
        o_any       = 1'b1;
      end
    end
    o_gnt = o_any ? (NUM_REQ'(1) << w_best) : '0;
    o_idx = GRANT_W'(w_best);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto a single UART transmitter with per-message locking.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_req_valid/data/last : per-requester byte, byte i on bits [8i+7:8i]
//   o_req_ready        : one-hot accept strobe (IDLE only)
//   o_tx_start/o_tx_data, i_tx_busy : UART transmitter handshake
//   o_grant_id/o_grant_active : current owner and message lock
//   o_err_timeout      : pulse when tx_busy never rose after a start
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic [GRANT_W-1:0]   o_grant_id,
  output logic                 o_grant_active,
  output logic                 o_err_timeout
);

  localparam int unsigned TimerW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  arb_state_e          r_state, w_state_d;
  logic [GRANT_W-1:0]  r_rr_ptr, r_owner;
  logic                r_lock, r_last;
  logic [7:0]          r_tx_data;
  logic [TimerW-1:0]   r_timer;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [GRANT_W-1:0]  w_pick_idx;
  logic                w_pick_any;

  logic [GRANT_W-1:0]  w_owner;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_owner_valid, w_owner_last, w_eligible, w_accept, w_msg_end;
  logic [7:0]          w_owner_data;
  logic [GRANT_W-1:0]  w_next_ptr;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .i_req(i_req_valid),
    .i_ptr(r_rr_ptr),
    .o_gnt(w_pick_gnt),
    .o_idx(w_pick_idx),
    .o_any(w_pick_any)
  );

  // While locked only the owner may be accepted, whatever the others request.
  assign w_owner    = r_lock ? r_owner : w_pick_idx;
  assign w_eligible = r_lock ? w_owner_valid : w_pick_any;
  assign w_next_ptr = (r_owner == GRANT_W'(NUM_REQ - 1)) ? '0 : r_owner + GRANT_W'(1);

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    w_owner_data  = '0;
    w_owner_oh    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_owner == GRANT_W'(i)) begin
        w_owner_valid = i_req_valid[i];
        w_owner_last  = i_req_last[i];
        w_owner_data  = i_req_data[8*i +: 8];
        w_owner_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_accept      = 1'b0;
    w_msg_end     = 1'b0;
    o_tx_start    = 1'b0;
    o_err_timeout = 1'b0;
    case (r_state)
      StIdle: begin
        // Reset gating keeps req_ready low while rst_n is asserted.
        if (i_rst_n && !i_tx_busy && w_eligible) begin
          w_accept  = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        o_tx_start = 1'b1;
        w_state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (i_tx_busy) begin
          w_state_d = StWaitDone;
        end else if (r_timer == TimerW'(BUSY_TIMEOUT - 1)) begin
          o_err_timeout = 1'b1;
          w_msg_end     = 1'b1;
          w_state_d     = StIdle;
        end
      end
      StWaitDone: begin
        if (!i_tx_busy) begin
          w_msg_end = r_last;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    o_req_ready = w_accept ? (r_lock ? w_owner_oh : w_pick_gnt) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_lock    <= 1'b0;
      r_last    <= 1'b0;
      r_tx_data <= '0;
      r_timer   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_tx_data <= w_owner_data;
        r_owner   <= w_owner;
        r_lock    <= 1'b1;
        r_last    <= w_owner_last;
      end
      if (r_state == StStart) begin
        r_timer <= '0;
      end else if (r_state == StWaitBusy) begin
        r_timer <= r_timer + TimerW'(1);
      end
      // Message completed or aborted: release the lock and rotate priority.
      if (w_msg_end) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign o_tx_data      = r_tx_data;
  assign o_grant_id     = r_owner;
  assign o_grant_active = r_lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 3;
  localparam int BT = 4;

  logic               clk, rst_n;
  logic [N-1:0]       req_valid, req_last, req_ready;
  logic [8*N-1:0]     req_data;
  logic               tx_start, tx_busy, grant_active, err_timeout;
  logic [7:0]         tx_data;
  logic [GRANT_W-1:0] grant_id;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .i_tx_busy(tx_busy),
    .o_grant_id(grant_id),
    .o_grant_active(grant_active),
    .o_err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks, n_fail, cyc;
  logic [8:0] q[N][$];   // per requester: {last, byte}
  int         log_q[$];
  int         exp_q[$];
  int         m_ptr, m_owner;
  bit         m_lock, rand_gaps;
  int         idle_at, start_at, err_at, busy_rise, busy_fall, to_idx;
  logic [7:0] exp_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Lowest valid index at or above the pointer, wrapping; owner only while locked.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    if (m_lock) begin
      for (int i = 0; i < N; i++) if (i == m_owner && v[i]) r[i] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        for (int i = 0; i < N; i++)
          if (r == '0 && i == (m_ptr + k) % N && v[i]) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_msg(input int r, input logic [7:0] b, input bit last);
    for (int i = 0; i < N; i++) if (i == r) q[i].push_back({last, b});
  endtask

  task automatic drive_reqs();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
        h = q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check_eq({tag, "_grant_active"}, 32'(grant_active), 32'd0);
    check_eq({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    log_q.delete();
    m_ptr = 0; m_owner = 0; m_lock = 1'b0;
    idle_at = cyc + 1; start_at = -1; err_at = -1; busy_rise = -1; busy_fall = -1;
    to_idx = -1; rand_gaps = 1'b0;
  endtask

  task automatic run_traffic(input int max_cycles);
    int n, idx, d, h;
    bit done;
    logic [N-1:0] exp_rdy;
    logic [8:0] ent;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      n++;
      tx_busy = (cyc >= busy_rise) && (cyc < busy_fall);
      drive_reqs();
      #1;
      exp_rdy = (cyc >= idle_at && !tx_busy) ? model_pick(req_valid) : '0;
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("tx_start", 32'(tx_start), 32'(cyc == start_at));
      check_eq("err_timeout", 32'(err_timeout), 32'(cyc == err_at));
      if (cyc == start_at) begin
        check_eq("tx_data", 32'(tx_data), 32'(exp_data));
        check_eq("grant_id", 32'(grant_id), 32'(m_owner));
        check_eq("grant_active_busy", 32'(grant_active), 32'd1);
      end
      if (cyc == idle_at) check_eq("grant_active_idle", 32'(grant_active), 32'(m_lock));
      if (exp_rdy != '0) begin
        idx = 0;
        ent = '0;
        for (int i = 0; i < N; i++) begin
          if (exp_rdy[i]) begin
            ent = q[i].pop_front();
            idx = i;
          end
        end
        log_q.push_back(idx);
        exp_data = ent[7:0];
        m_owner  = idx;
        start_at = cyc + 1;
        if (log_q.size() - 1 == to_idx) begin
          // UART never answers: abort after BT cycles, drop lock, rotate.
          err_at    = start_at + BT;
          idle_at   = err_at + 1;
          busy_rise = -1;
          busy_fall = -1;
          m_lock    = 1'b0;
          m_ptr     = (idx + 1) % N;
        end else begin
          d = int'($urandom_range(0, 2));
          h = int'($urandom_range(1, 3));
          busy_rise = cyc + 2 + d;
          busy_fall = busy_rise + h;
          idle_at   = busy_fall + 1;
          m_lock    = !ent[8];
          if (ent[8]) m_ptr = (idx + 1) % N;
        end
      end
      if (all_empty() && cyc >= idle_at) begin
        done = 1'b1;
      end else if (n >= max_cycles) begin
        check_eq("drain_bound", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq(tag, 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b1; tx_busy = 1'b0; req_valid = '0; req_last = '0; req_data = '0;

    // Single byte from requester 0.
    do_reset();
    push_msg(0, 8'h41, 1'b1);
    run_traffic(200);
    exp_q = {0};
    check_log("single_byte");

    // tx_busy already high in IDLE holds off the accept.
    do_reset();
    busy_rise = cyc + 1;
    busy_fall = cyc + 5;
    push_msg(0, 8'h42, 1'b1);
    run_traffic(200);

    // Round robin with wrap.
    do_reset();
    push_msg(0, 8'hA0, 1'b1); push_msg(0, 8'hA3, 1'b1);
    push_msg(1, 8'hA1, 1'b1);
    push_msg(2, 8'hA2, 1'b1);
    run_traffic(400);
    exp_q = {0, 1, 2, 0};
    check_log("rr_order");

    // Message lock keeps requester 0 waiting.
    do_reset();
    push_msg(0, 8'h10, 1'b1); push_msg(0, 8'h11, 1'b1);
    push_msg(1, 8'h31, 1'b0); push_msg(1, 8'h32, 1'b0); push_msg(1, 8'h33, 1'b1);
    run_traffic(400);
    exp_q = {0, 1, 1, 1, 0};
    check_log("msg_lock");

    // Busy timeout on a non-final byte: lock released, pointer rotated to 0.
    do_reset();
    to_idx = 0;
    push_msg(2, 8'h55, 1'b0);
    run_traffic(200);
    push_msg(1, 8'h11, 1'b1);
    push_msg(2, 8'h56, 1'b1);
    run_traffic(400);
    exp_q = {2, 1, 2};
    check_log("timeout");

    // Randomized traffic with valid gaps.
    do_reset();
    rand_gaps = 1'b1;
    for (int m = 0; m < 30; m++) begin
      int r, len;
      r   = int'($urandom_range(0, N - 1));
      len = int'($urandom_range(1, 3));
      for (int b = 0; b < len; b++) push_msg(r, 8'($urandom), b == len - 1);
    end
    run_traffic(6000);

    // Reset while a byte is in WAIT_DONE.
    do_reset();
    @(negedge clk);
    req_valid = 3'b010; req_data = {8'h00, 8'h31, 8'h00}; req_last = 3'b000; tx_busy = 1'b0;
    #1 check_eq("mid_accept", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 3'b011; req_data = {8'h00, 8'h32, 8'hA0}; req_last = 3'b001; tx_busy = 1'b1;
    #1 check_eq("mid_tx_start", 32'(tx_start), 32'd1);
    check_eq("mid_tx_data", 32'(tx_data), 32'h31);
    @(negedge clk);
    #1 check_eq("mid_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1; tx_busy = 1'b0;
    #1 check_eq("post_reset_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
